// File: rtl/crosswalk_pkg.sv
// ============================================================================
// Module   : crosswalk_pkg
// Purpose  : Shared state, signal-select constants and helpers for the
//            pedestrian crossing controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package crosswalk_pkg;

  typedef enum logic [1:0] {
    DONT_WALK = 2'd0,
    REQUEST   = 2'd1,
    WALK      = 2'd2,
    CLEARANCE = 2'd3
  } state_e;

  localparam logic [1:0] HAND_OFF   = 2'b00;
  localparam logic [1:0] HAND_BLINK = 2'b01;
  localparam logic [1:0] HAND_SOLID = 2'b11;

  localparam logic PERSON_ON  = 1'b0;
  localparam logic PERSON_OFF = 1'b1;

  // A zero duration is meaningless for a phase, so it is promoted to one.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crosswalk_timer.sv
// ============================================================================
// Module   : crosswalk_timer
// Purpose  : Loadable tick-gated down-counter; expire_o marks the tick that
//            takes the count from one to zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crosswalk_timer #(
  parameter int unsigned CW        = 4,
  parameter int unsigned RESET_VAL = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          tick_i,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic [CW-1:0] count_o,
  output logic          expire_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= CW'(RESET_VAL);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o  = count_q;
  assign expire_o = tick_i && (count_q == CW'(1));

endmodule

`default_nettype wire

// File: rtl/crosswalk_controller.sv
// ============================================================================
// Module   : crosswalk_controller
// Purpose  : Pedestrian crossing sequencer: request latch, vehicle grant
//            handshake, walk/clearance/don't-walk timing and hand blink.
//            Optional feature macro: CROSSWALK_COUNTDOWN_EN (adds countdown).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module crosswalk_controller
  import crosswalk_pkg::*;
#(
  parameter int unsigned WALK_TICKS          = 7,
  parameter int unsigned CLEAR_TICKS         = 10,
  parameter int unsigned MIN_DONT_WALK_TICKS = 5,
  parameter int unsigned BLINK_HALF_CYCLES   = 25000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       button,
  input  logic       vehStopped,
  output logic       walkReq,
  output logic [1:0] fsmHandControl,
  output logic       fsmPersonControl,
  output logic       blink
`ifdef CROSSWALK_COUNTDOWN_EN
  ,
  output logic [5:0] countdown
`endif
);

  localparam int unsigned WALK_T  = at_least_one(WALK_TICKS);
  localparam int unsigned CLEAR_T = at_least_one(CLEAR_TICKS);
  localparam int unsigned MIN_T   = at_least_one(MIN_DONT_WALK_TICKS);
  localparam int unsigned HALF    = at_least_one(BLINK_HALF_CYCLES);
  localparam int unsigned MAX_T   = (WALK_T > CLEAR_T) ?
                                    ((WALK_T > MIN_T) ? WALK_T : MIN_T) :
                                    ((CLEAR_T > MIN_T) ? CLEAR_T : MIN_T);
  localparam int unsigned CW      = $clog2(MAX_T + 1);
  localparam int unsigned BW      = (HALF > 1) ? $clog2(HALF) : 1;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            blink_q, blink_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            t_load;
  logic [CW-1:0]   t_load_val;
  logic [CW-1:0]   t_count;
  logic            t_expire;
  logic            t_done;

  crosswalk_timer #(
    .CW        (CW),
    .RESET_VAL (MIN_T)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick_i     (tick),
    .load_i     (t_load),
    .load_val_i (t_load_val),
    .count_o    (t_count),
    .expire_o   (t_expire)
  );

  // Once the don't-walk dwell has run out it stays satisfied until reloaded.
  assign t_done = (t_count == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DONT_WALK: if ((t_expire || t_done) && req_q) state_d = REQUEST;
      REQUEST:   if (vehStopped) state_d = WALK;
      WALK:      if (!vehStopped || t_expire) state_d = CLEARANCE;
      CLEARANCE: if (t_expire) state_d = DONT_WALK;
      default:   state_d = DONT_WALK;
    endcase

    t_load     = (state_d != state_q);
    t_load_val = CW'(MIN_T);
    if (state_d == WALK) begin
      t_load_val = CW'(WALK_T);
    end else if (state_d == CLEARANCE) begin
      t_load_val = CW'(CLEAR_T);
    end

    req_d = req_q;
    if ((state_d == WALK) && (state_q != WALK)) begin
      req_d = 1'b0;
    end else if (button && (state_q != WALK)) begin
      req_d = 1'b1;
    end

    blink_d = 1'b0;
    bcnt_d  = '0;
    if (state_d == CLEARANCE) begin
      if (state_q != CLEARANCE) begin
        blink_d = 1'b1;
      end else if (bcnt_q == BW'(HALF - 1)) begin
        blink_d = ~blink_q;
      end else begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= DONT_WALK;
      req_q   <= 1'b0;
      blink_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      blink_q <= blink_d;
      bcnt_q  <= bcnt_d;
    end
  end

  assign walkReq          = (state_q == REQUEST);
  assign fsmHandControl   = (state_q == WALK)      ? HAND_OFF   :
                            (state_q == CLEARANCE) ? HAND_BLINK : HAND_SOLID;
  assign fsmPersonControl = (state_q == WALK) ? PERSON_ON : PERSON_OFF;
  assign blink            = blink_q;

`ifdef CROSSWALK_COUNTDOWN_EN
  logic [31:0] w_count32;
  assign w_count32 = 32'(t_count);
  assign countdown = (state_q != CLEARANCE) ? 6'd0 :
                     (w_count32 > 32'd63)   ? 6'd63 : w_count32[5:0];
`endif

endmodule

`default_nettype wire

// File: doc/crosswalk_controller.md
# crosswalk_controller

Sequential controller for one pedestrian crossing: latches push-button requests, handshakes with the vehicle signal controller for a stopped-traffic grant, and times the walk / clearance / don't-walk phases. Drives the pedestrian signal stage directly with its hand-LED select, person-LED select and blink waveform. Sits directly upstream of the pedestrian signal block, which is purely combinational.

## Interface
Parameters:
- WALK_TICKS, 7, duration of walk phase in ticks
- CLEAR_TICKS, 10, duration of flashing-hand clearance phase in ticks
- MIN_DONT_WALK_TICKS, 5, minimum solid-hand dwell before the next request is served
- BLINK_HALF_CYCLES, 25000000, clk cycles per blink half-period

Ports:
- clk  in  1  system clock; single clock domain
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk
- tick  in  1  one-cycle timing strobe (nominally 1 Hz)
- button  in  1  pedestrian push-button, already synchronised and debounced
- vehStopped  in  1  vehicle controller grant: traffic is held at red
- walkReq  out  1  request to vehicle controller to stop traffic
- fsmHandControl  out  2  hand select: 2'b00 off, 2'b01 blink, 2'b11 solid, 2'b10 unused/off
- fsmPersonControl  out  1  person select: 0 = lit, 1 = off
- blink  out  1  blink waveform for the hand LED

## Operation
- States: DONT_WALK, REQUEST, WALK, CLEARANCE.
- DONT_WALK: hand 2'b11, person 1. The down-counter is loaded with MIN_DONT_WALK_TICKS on entry. Go to REQUEST when the counter has expired and reqLatched=1.
- REQUEST: hand 2'b11, person 1, walkReq=1. Go to WALK on the first cycle vehStopped=1.
- WALK: hand 2'b00, person 0. Counter loaded with WALK_TICKS. Go to CLEARANCE when it expires.
- WALK abort: if vehStopped=0 in any WALK cycle, go to CLEARANCE on the next edge. This is a safety rule and has priority over expiry.
- CLEARANCE: hand 2'b01, person 1. Counter loaded with CLEAR_TICKS. Go to DONT_WALK on expiry. vehStopped is ignored in this state.
- Counter semantics:
  - Decrements only on cycles with tick=1.
  - Expiry is the cycle where tick=1 and count==1, so a phase lasts exactly N ticks.
  - A parameter value of 0 is treated as 1.
- Request latch:
  - reqLatched is set by button=1 in DONT_WALK, REQUEST or CLEARANCE.
  - button is ignored in WALK.
  - reqLatched clears on the edge that enters WALK.
  - A button press on the same cycle as the DONT_WALK→REQUEST transition is harmless (the latch is already set).
- Blink:
  - A cycle counter toggles blink every BLINK_HALF_CYCLES clk cycles while in CLEARANCE.
  - On entry to CLEARANCE, blink=1 and the cycle counter is 0.
  - Outside CLEARANCE, blink is held at 0.
- Outputs are decoded from registered state (Moore) plus the registered blink flop.

## Timing
- Reset (reset_n=0 at an edge):
  - state DONT_WALK, counter = MIN_DONT_WALK_TICKS, reqLatched=0
  - blink=0, walkReq=0, fsmHandControl=2'b11, fsmPersonControl=1
  - Reset mid-phase (e.g. during WALK) returns to these values on the next edge. The clearance phase is not completed.
- button→reqLatched: 1 cycle.
- vehStopped in REQUEST → WALK outputs visible 1 cycle later.
- Phase change is visible on the cycle after the expiring tick.
- walkReq deasserts in the same cycle WALK outputs appear.

## Configuration
- CROSSWALK_COUNTDOWN_EN defined:
  - Adds output `countdown` (out, 6 bits).
  - In CLEARANCE it carries the remaining ticks, saturated at 63: CLEAR_TICKS on entry, decrementing per tick.
  - It is 0 in all other states and at reset.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package crosswalk_pkg holds:
  - the state enum (DONT_WALK, REQUEST, WALK, CLEARANCE)
  - hand-select constants HAND_OFF=2'b00, HAND_BLINK=2'b01, HAND_SOLID=2'b11
  - person constants PERSON_ON=1'b0, PERSON_OFF=1'b1
- One sub-module, crosswalk_timer: a loadable tick-gated down-counter with expire output, reused for all three phases.

## Test plan
Common bench parameters: WALK_TICKS=3, CLEAR_TICKS=4, MIN_DONT_WALK_TICKS=2, BLINK_HALF_CYCLES=2, tick every 5 cycles.
- Reset: hold reset_n=0 for 3 cycles, then release → hand 2'b11, person 1, blink 0, walkReq 0. With no button press, the outputs stay there indefinitely.
- Full cycle: pulse button after 2 ticks, vehStopped=1 constant → walkReq 1 for 1 cycle; WALK for exactly 3 ticks; CLEARANCE for 4 ticks with blink toggling every 2 cycles starting at 1; return to hand 2'b11.
- Grant wait: button pressed, vehStopped=0 for 20 cycles → walkReq stays 1 and hand stays 2'b11 throughout. Raising vehStopped gives person 0 on the next cycle.
- Abort: drop vehStopped after 1 tick of WALK → next cycle hand 2'b01, person 1, and a full 4-tick clearance follows.
- Request during clearance: press button in CLEARANCE → after DONT_WALK (2 ticks), REQUEST is entered automatically. A press during WALK alone produces no second walk.
- Mid-phase reset: assert reset_n=0 during CLEARANCE → next cycle hand 2'b11, blink 0, countdown 0 (with CROSSWALK_COUNTDOWN_EN); the latch is cleared.
